uartlite_rx_poller: RTL and testbench

UARTLITE_RX_POLLER -- requirements
Module: uartlite_rx_poller

---
 rtl/uartlite_rx_poller_if.sv | 31 +++
 rtl/uartlite_rx_poller.sv | 162 ++++++++++++++++
 tb/tb_uartlite_rx_poller.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/uartlite_rx_poller_if.sv
// AXI4-Lite bus between the RX poller (master) and a Xilinx UART-Lite core (slave).
// Only the channels the poller actually uses are present; no prot/cache signals.
interface uartlite_rx_poller_if;
    logic [3:0]  awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [3:0]  araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/uartlite_rx_poller.sv
// Polls a UART-Lite status register over AXI4-Lite and streams received bytes out.
// One AXI transaction in flight at a time; the RX FIFO is reset once after rst_n.
module uartlite_rx_poller #(
    parameter int unsigned POLL_INTERVAL = 16,
    parameter logic [7:0]  LAST_CHAR     = 8'h0A
) (
    input  logic                        clk,
    input  logic                        rst_n,
    uartlite_rx_poller_if.master        m_axi,
    output logic [7:0]                  out_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        eol_o,
    output logic [15:0]                 rx_count,
    output logic                        err_o
);

    typedef enum logic [2:0] {
        INIT_W,
        INIT_B,
        IDLE,
        STAT_AR,
        STAT_R,
        DATA_AR,
        DATA_R,
        OUT
    } state_t;

    localparam logic [15:0] POLL_RELOAD = 16'(POLL_INTERVAL - 1);
    localparam logic [3:0]  ADDR_RX     = 4'h0;
    localparam logic [3:0]  ADDR_STAT   = 4'h8;
    localparam logic [3:0]  ADDR_CTRL   = 4'hC;

    state_t      state;
    logic [15:0] poll_cnt;
    logic        init_issued;
    logic        rdata_unused;

    // Upper data bits carry nothing the poller needs.
    assign rdata_unused = ^m_axi.rdata[31:8];

    // Single registered FSM; every bus output is a flop, so valids never
    // depend combinationally on the slave's ready inputs.  The first cycle
    // after reset only raises the init write, which is why init_issued exists.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= INIT_W;
            init_issued    <= 1'b0;
            poll_cnt       <= '0;
            m_axi.awaddr   <= '0;
            m_axi.awvalid  <= 1'b0;
            m_axi.wdata    <= '0;
            m_axi.wstrb    <= '0;
            m_axi.wvalid   <= 1'b0;
            m_axi.bready   <= 1'b0;
            m_axi.araddr   <= '0;
            m_axi.arvalid  <= 1'b0;
            m_axi.rready   <= 1'b0;
            out_data       <= '0;
            out_valid      <= 1'b0;
            rx_count       <= '0;
            eol_o          <= 1'b0;
            err_o          <= 1'b0;
        end else begin
            eol_o <= 1'b0;
            case (state)
                INIT_W: begin
                    if (!init_issued) begin
                        init_issued   <= 1'b1;
                        m_axi.awaddr  <= ADDR_CTRL;
                        m_axi.wdata   <= 32'h0000_0002;
                        m_axi.wstrb   <= 4'hF;
                        m_axi.awvalid <= 1'b1;
                        m_axi.wvalid  <= 1'b1;
                    end else begin
                        if (m_axi.awready) m_axi.awvalid <= 1'b0;
                        if (m_axi.wready)  m_axi.wvalid  <= 1'b0;
                        if ((!m_axi.awvalid || m_axi.awready) &&
                            (!m_axi.wvalid  || m_axi.wready)) begin
                            m_axi.bready <= 1'b1;
                            state        <= INIT_B;
                        end
                    end
                end
                INIT_B: begin
                    if (m_axi.bvalid) begin
                        m_axi.bready <= 1'b0;
                        if (m_axi.bresp != 2'b00) err_o <= 1'b1;
                        poll_cnt <= POLL_RELOAD;
                        state    <= IDLE;
                    end
                end
                IDLE: begin
                    if (poll_cnt == 16'd0) begin
                        m_axi.araddr  <= ADDR_STAT;
                        m_axi.arvalid <= 1'b1;
                        state         <= STAT_AR;
                    end else begin
                        poll_cnt <= poll_cnt - 16'd1;
                    end
                end
                STAT_AR: begin
                    if (m_axi.arready) begin
                        m_axi.arvalid <= 1'b0;
                        m_axi.rready  <= 1'b1;
                        state         <= STAT_R;
                    end
                end
                STAT_R: begin
                    if (m_axi.rvalid) begin
                        m_axi.rready <= 1'b0;
                        if (m_axi.rresp != 2'b00) begin
                            err_o    <= 1'b1;
                            poll_cnt <= POLL_RELOAD;
                            state    <= IDLE;
                        end else if (m_axi.rdata[0]) begin
                            m_axi.araddr  <= ADDR_RX;
                            m_axi.arvalid <= 1'b1;
                            state         <= DATA_AR;
                        end else begin
                            poll_cnt <= POLL_RELOAD;
                            state    <= IDLE;
                        end
                    end
                end
                DATA_AR: begin
                    if (m_axi.arready) begin
                        m_axi.arvalid <= 1'b0;
                        m_axi.rready  <= 1'b1;
                        state         <= DATA_R;
                    end
                end
                DATA_R: begin
                    if (m_axi.rvalid) begin
                        m_axi.rready <= 1'b0;
                        if (m_axi.rresp != 2'b00) begin
                            err_o    <= 1'b1;
                            poll_cnt <= POLL_RELOAD;
                            state    <= IDLE;
                        end else begin
                            out_data  <= m_axi.rdata[7:0];
                            out_valid <= 1'b1;
                            state     <= OUT;
                        end
                    end
                end
                OUT: begin
                    // Drain the FIFO back-to-back: re-poll status immediately.
                    if (out_ready) begin
                        out_valid     <= 1'b0;
                        rx_count      <= rx_count + 16'd1;
                        eol_o         <= (out_data == LAST_CHAR);
                        m_axi.araddr  <= ADDR_STAT;
                        m_axi.arvalid <= 1'b1;
                        state         <= STAT_AR;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uartlite_rx_poller.sv
// Directed bench for uartlite_rx_poller: a scripted UART-Lite slave answers each
// AXI transaction by hand and every step is checked with an immediate assertion.
module tb_uartlite_rx_poller;

    localparam int unsigned POLL = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        eol_o;
    logic [15:0] rx_count;
    logic        err_o;

    int checks = 0;
    int failures = 0;
    int aw_hs = 0;
    int w_hs = 0;
    int ar_hs = 0;
    int eol_count = 0;
    int waited;
    int ar_before;
    int eol_before;

    uartlite_rx_poller_if axi ();

    uartlite_rx_poller #(
        .POLL_INTERVAL (POLL),
        .LAST_CHAR     (8'h0A)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .m_axi     (axi),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .eol_o     (eol_o),
        .rx_count  (rx_count),
        .err_o     (err_o)
    );

    always #5 clk = ~clk;

    // Handshake and pulse monitors used to detect extra or missing transfers.
    always @(posedge clk) begin
        if (axi.awvalid === 1'b1 && axi.awready === 1'b1) aw_hs <= aw_hs + 1;
        if (axi.wvalid === 1'b1 && axi.wready === 1'b1)   w_hs  <= w_hs + 1;
        if (axi.arvalid === 1'b1 && axi.arready === 1'b1) ar_hs <= ar_hs + 1;
    end

    always @(negedge clk) begin
        if (eol_o === 1'b1) eol_count <= eol_count + 1;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulusIdleBus();
        axi.awready = 1'b0;
        axi.wready  = 1'b0;
        axi.bvalid  = 1'b0;
        axi.bresp   = 2'b00;
        axi.arready = 1'b1;
        axi.rvalid  = 1'b0;
        axi.rdata   = 32'h0;
        axi.rresp   = 2'b00;
        out_ready   = 1'b0;
    endtask

    task automatic applyReset();
        rst_n = 1'b0;
        applyStimulusIdleBus();
        repeat (2) @(negedge clk);
        checkOutput("rst_awvalid", 32'(axi.awvalid), 32'd0);
        checkOutput("rst_wvalid",  32'(axi.wvalid),  32'd0);
        checkOutput("rst_arvalid", 32'(axi.arvalid), 32'd0);
        checkOutput("rst_rready",  32'(axi.rready),  32'd0);
        checkOutput("rst_bready",  32'(axi.bready),  32'd0);
        checkOutput("rst_awaddr",  32'(axi.awaddr),  32'd0);
        checkOutput("rst_wdata",   axi.wdata,        32'd0);
        checkOutput("rst_outv",    32'(out_valid),   32'd0);
        checkOutput("rst_count",   32'(rx_count),    32'd0);
        checkOutput("rst_err",     32'(err_o),       32'd0);
        rst_n = 1'b1;
    endtask

    // Init write with awready/wready raised after the given number of cycles.
    task automatic serveWrite(input int aw_lat, input int w_lat, input logic [1:0] resp);
        int n;
        int aw0;
        int w0;
        n = 0;
        while (axi.awvalid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput("aw_start", 32'(axi.awvalid), 32'd1);
        checkOutput("wv_start", 32'(axi.wvalid),  32'd1);
        checkOutput("awaddr",   32'(axi.awaddr),  32'hC);
        checkOutput("wdata",    axi.wdata,        32'h2);
        checkOutput("wstrb",    32'(axi.wstrb),   32'hF);
        aw0 = aw_hs;
        w0  = w_hs;
        for (int k = 0; k <= ((aw_lat > w_lat) ? aw_lat : w_lat); k++) begin
            axi.awready = (k >= aw_lat);
            axi.wready  = (k >= w_lat);
            @(negedge clk);
        end
        axi.awready = 1'b0;
        axi.wready  = 1'b0;
        checkOutput("aw_once",   32'(aw_hs - aw0), 32'd1);
        checkOutput("w_once",    32'(w_hs - w0),   32'd1);
        checkOutput("aw_drop",   32'(axi.awvalid), 32'd0);
        checkOutput("bready_up", 32'(axi.bready),  32'd1);
        axi.bvalid = 1'b1;
        axi.bresp  = resp;
        @(negedge clk);
        axi.bvalid = 1'b0;
        axi.bresp  = 2'b00;
        checkOutput("bready_dn", 32'(axi.bready), 32'd0);
    endtask

    // Waits for an AR (counting idle cycles), then returns one R beat.
    task automatic serveRead(input logic [3:0] addr, input logic [31:0] data, input logic [1:0] resp, output int n);
        n = 0;
        while (axi.arvalid !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checkOutput("ar_seen", 32'(axi.arvalid), 32'd1);
        checkOutput("araddr",  32'(axi.araddr),  32'(addr));
        @(negedge clk);
        checkOutput("rready",  32'(axi.rready),  32'd1);
        axi.rvalid = 1'b1;
        axi.rdata  = data;
        axi.rresp  = resp;
        @(negedge clk);
        axi.rvalid = 1'b0;
        axi.rdata  = 32'h0;
        axi.rresp  = 2'b00;
    endtask

    task automatic consumeByte(input logic [7:0] b, input int stall, input logic exp_eol, input logic [15:0] exp_cnt);
        int ar0;
        checkOutput("out_valid", 32'(out_valid), 32'd1);
        checkOutput("out_data",  32'(out_data),  32'(b));
        ar0 = ar_hs;
        for (int i = 0; i < stall; i++) @(negedge clk);
        checkOutput("stall_valid", 32'(out_valid),   32'd1);
        checkOutput("stall_data",  32'(out_data),    32'(b));
        checkOutput("stall_noar",  32'(ar_hs - ar0), 32'd0);
        checkOutput("stall_arv",   32'(axi.arvalid), 32'd0);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checkOutput("out_drop", 32'(out_valid),   32'd0);
        checkOutput("eol",      32'(eol_o),       32'(exp_eol));
        checkOutput("rx_count", 32'(rx_count),    32'(exp_cnt));
        checkOutput("next_ar",  32'(axi.arvalid), 32'd1);
        checkOutput("next_adr", 32'(axi.araddr),  32'h8);
    endtask

    initial begin
        $display("[TB] start");
        applyReset();

        // Init write, then empty status polls spaced by POLL idle cycles.
        serveWrite(0, 0, 2'b00);
        checkOutput("err_ok", 32'(err_o), 32'd0);
        serveRead(4'h8, 32'h0, 2'b00, waited);
        checkOutput("gap_init", 32'(waited), POLL);
        serveRead(4'h8, 32'h0, 2'b00, waited);
        checkOutput("gap_poll", 32'(waited), POLL);
        checkOutput("no_byte", 32'(out_valid), 32'd0);

        // Single byte, consumer ready.
        serveRead(4'h8, 32'h1, 2'b00, waited);
        checkOutput("gap_poll2", 32'(waited), POLL);
        serveRead(4'h0, 32'hFFFF_FF41, 2'b00, waited);
        checkOutput("data_nogap", 32'(waited), 32'd0);
        consumeByte(8'h41, 0, 1'b0, 16'd1);

        // "Hi\n" with a 10-cycle stall per byte.
        eol_before = eol_count;
        serveRead(4'h8, 32'h1, 2'b00, waited);
        checkOutput("drain_nogap", 32'(waited), 32'd0);
        serveRead(4'h0, 32'h48, 2'b00, waited);
        consumeByte(8'h48, 10, 1'b0, 16'd2);
        serveRead(4'h8, 32'h1, 2'b00, waited);
        serveRead(4'h0, 32'h69, 2'b00, waited);
        consumeByte(8'h69, 10, 1'b0, 16'd3);
        serveRead(4'h8, 32'h1, 2'b00, waited);
        serveRead(4'h0, 32'h0A, 2'b00, waited);
        consumeByte(8'h0A, 10, 1'b1, 16'd4);
        serveRead(4'h8, 32'h0, 2'b00, waited);
        checkOutput("eol_once", 32'(eol_count - eol_before), 32'd1);
        checkOutput("eol_low", 32'(eol_o), 32'd0);

        // Zero byte is forwarded.
        serveRead(4'h8, 32'h1, 2'b00, waited);
        checkOutput("gap_after", 32'(waited), POLL);
        serveRead(4'h0, 32'h0, 2'b00, waited);
        consumeByte(8'h00, 0, 1'b0, 16'd5);
        serveRead(4'h8, 32'h0, 2'b00, waited);

        // Data read error: sticky err, no byte, polling resumes.
        ar_before = ar_hs;
        serveRead(4'h8, 32'h1, 2'b00, waited);
        serveRead(4'h0, 32'h77, 2'b10, waited);
        checkOutput("rerr_set", 32'(err_o), 32'd1);
        checkOutput("rerr_nobyte", 32'(out_valid), 32'd0);
        serveRead(4'h8, 32'h1, 2'b00, waited);
        checkOutput("rerr_gap", 32'(waited), POLL);
        serveRead(4'h0, 32'h33, 2'b00, waited);
        consumeByte(8'h33, 2, 1'b0, 16'd6);
        checkOutput("rerr_sticky", 32'(err_o), 32'd1);

        // Reset during DATA_R with rvalid pending.
        serveRead(4'h8, 32'h1, 2'b00, waited);
        checkOutput("dr_arv", 32'(axi.arvalid), 32'd1);
        checkOutput("dr_adr", 32'(axi.araddr),  32'h0);
        @(negedge clk);
        axi.rvalid = 1'b1;
        axi.rdata  = 32'h55;
        #1 rst_n = 1'b0;
        #1;
        checkOutput("mid_rready", 32'(axi.rready),  32'd0);
        checkOutput("mid_arvalid", 32'(axi.arvalid), 32'd0);
        checkOutput("mid_araddr", 32'(axi.araddr),  32'd0);
        checkOutput("mid_outv",   32'(out_valid),   32'd0);
        checkOutput("mid_outd",   32'(out_data),    32'd0);
        checkOutput("mid_count",  32'(rx_count),    32'd0);
        checkOutput("mid_err",    32'(err_o),       32'd0);
        applyReset();
        serveWrite(0, 0, 2'b00);
        serveRead(4'h8, 32'h0, 2'b00, waited);
        checkOutput("mid_gap", 32'(waited), POLL);

        // Skewed write handshakes, both orders; then a bresp error.
        applyReset();
        serveWrite(1, 2, 2'b00);
        serveRead(4'h8, 32'h0, 2'b00, waited);
        checkOutput("skew1_gap", 32'(waited), POLL);
        applyReset();
        serveWrite(2, 1, 2'b10);
        checkOutput("berr_set", 32'(err_o), 32'd1);
        serveRead(4'h8, 32'h0, 2'b00, waited);
        checkOutput("berr_poll", 32'(waited), POLL);
        checkOutput("berr_sticky", 32'(err_o), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
